// File: rtl/ctrl_sequencer.sv
// Multi-cycle instruction sequencer for the minicpu datapath: fetches over valid/ready, then
// drives active-low loads and source select for one execute cycle, with WAIT and sticky HALT.
module ctrl_sequencer #(
  parameter int unsigned NREG = 2,
  parameter int unsigned DW   = 4,
  localparam int unsigned RW  = (NREG > 2) ? $clog2(NREG) : 1,
  localparam int unsigned SW  = $clog2(NREG + 2),
  localparam int unsigned IW  = 4 + RW + DW
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [IW-1:0]     instr,
  input  logic              c_in,
  output logic [NREG+1:0]   ld,
  output logic [SW-1:0]     sel,
  output logic [DW-1:0]     imm,
  output logic              pc_inc,
  output logic              halted
);

  localparam int unsigned LW = NREG + 2;
  localparam logic [SW-1:0] SelIn   = SW'(NREG);
  localparam logic [SW-1:0] SelZero = SW'(NREG + 1);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpMovI = 4'd1;
  localparam logic [3:0] OpMovR = 4'd2;
  localparam logic [3:0] OpIn   = 4'd3;
  localparam logic [3:0] OpOutI = 4'd4;
  localparam logic [3:0] OpOutR = 4'd5;
  localparam logic [3:0] OpJmp  = 4'd6;
  localparam logic [3:0] OpJnc  = 4'd7;
  localparam logic [3:0] OpWait = 4'd8;
  localparam logic [3:0] OpHalt = 4'd9;

  typedef enum logic [1:0] {StFetch, StExec, StWait, StHalt} state_e;

  state_e          state_q;
  logic [3:0]      op_q;
  logic [DW-1:0]   cnt_q;
  logic            c_flag_q;
  logic [LW-1:0]   ld_q;
  logic [SW-1:0]   sel_q;
  logic [DW-1:0]   imm_q;
  logic            pc_inc_q;
  logic            halted_q;

  logic [3:0]      in_op;
  logic [RW-1:0]   in_rd;
  logic [RW-1:0]   in_rs;
  logic [DW-1:0]   in_imm;
  logic            rd_ok;
  logic            rs_ok;
  logic [LW-1:0]   dec_ld;
  logic [SW-1:0]   dec_sel;
  logic            dec_pc_inc;
  logic            pc_load;

  assign in_op  = instr[IW-1 -: 4];
  assign in_rd  = instr[DW +: RW];
  assign in_imm = instr[DW-1:0];
  assign in_rs  = in_imm[RW-1:0];
  assign rd_ok  = (32'(in_rd) < NREG);
  assign rs_ok  = (32'(in_rs) < NREG);

  // Decode happens at accept time so the execute-cycle outputs come straight from flops.
  // c_flag_q is already final here: it only changes at the end of an execute cycle.
  always_comb begin
    dec_ld  = '1;
    dec_sel = SelZero;
    pc_load = 1'b0;
    case (in_op)
      OpAdd: begin
        if (rd_ok) begin
          dec_ld  = ~(LW'(1) << in_rd);
          dec_sel = SW'(in_rd);
        end
      end
      OpMovI: begin
        if (rd_ok) dec_ld = ~(LW'(1) << in_rd);
      end
      OpMovR: begin
        if (rd_ok && rs_ok) begin
          dec_ld  = ~(LW'(1) << in_rd);
          dec_sel = SW'(in_rs);
        end
      end
      OpIn: begin
        if (rd_ok) begin
          dec_ld  = ~(LW'(1) << in_rd);
          dec_sel = SelIn;
        end
      end
      OpOutI: dec_ld[NREG] = 1'b0;
      OpOutR: begin
        if (rd_ok) begin
          dec_ld[NREG] = 1'b0;
          dec_sel      = SW'(in_rd);
        end
      end
      OpJmp: pc_load = 1'b1;
      OpJnc: pc_load = ~c_flag_q;
      default: ;
    endcase
    if (pc_load) dec_ld[LW-1] = 1'b0;
    dec_pc_inc = ~pc_load & (in_op != OpHalt);
  end

  assign instr_ready = n_reset & (state_q == StFetch);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q  <= StFetch;
      op_q     <= '0;
      cnt_q    <= '0;
      c_flag_q <= 1'b0;
      ld_q     <= '1;
      sel_q    <= SelZero;
      imm_q    <= '0;
      pc_inc_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        StFetch: begin
          if (instr_valid) begin
            state_q  <= StExec;
            op_q     <= in_op;
            imm_q    <= in_imm;
            ld_q     <= dec_ld;
            sel_q    <= dec_sel;
            pc_inc_q <= dec_pc_inc;
          end
        end
        StExec: begin
          c_flag_q <= c_in;
          ld_q     <= '1;
          sel_q    <= SelZero;
          pc_inc_q <= 1'b0;
          if (op_q == OpWait && imm_q != '0) begin
            state_q <= StWait;
            cnt_q   <= imm_q;
          end else if (op_q == OpHalt) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end else begin
            state_q <= StFetch;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - DW'(1);
          if (cnt_q == DW'(1)) state_q <= StFetch;
        end
        StHalt: ;
        default: state_q <= StFetch;
      endcase
    end
  end

  assign ld     = ld_q;
  assign sel    = sel_q;
  assign imm    = imm_q;
  assign pc_inc = pc_inc_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer (NREG=2, DW=4): directed literal checks plus randomized traffic
// checked every cycle against a schedule-based model of the sequencer.
module tb_ctrl_sequencer;

  logic       clk;
  logic       n_reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [8:0] instr;
  logic       c_in;
  logic [3:0] ld;
  logic [1:0] sel;
  logic [3:0] imm;
  logic       pc_inc;
  logic       halted;

  int total = 0;
  int bad   = 0;

  ctrl_sequencer #(.NREG(2), .DW(4)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .c_in        (c_in),
    .ld          (ld),
    .sel         (sel),
    .imm         (imm),
    .pc_inc      (pc_inc),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One expected output cycle; a scheduled list of these describes an accepted instruction.
  typedef struct {
    logic [3:0] ld;
    logic [1:0] sel;
    logic       pc_inc;
    logic       exec;
    logic       halt;
  } exp_t;

  function automatic exp_t decode(input logic [8:0] ins, input logic cf);
    exp_t e;
    logic [3:0] op;
    logic       rd;
    logic       rs;
    op = ins[8:5];
    rd = ins[4];
    rs = ins[0];
    e.ld = 4'hF; e.sel = 2'd3; e.pc_inc = 1'b1; e.exec = 1'b1; e.halt = 1'b0;
    case (op)
      4'd0: begin e.ld[rd] = 1'b0; e.sel = {1'b0, rd}; end
      4'd1: e.ld[rd] = 1'b0;
      4'd2: begin e.ld[rd] = 1'b0; e.sel = {1'b0, rs}; end
      4'd3: begin e.ld[rd] = 1'b0; e.sel = 2'd2; end
      4'd4: e.ld[2] = 1'b0;
      4'd5: begin e.ld[2] = 1'b0; e.sel = {1'b0, rd}; end
      4'd6: begin e.ld[3] = 1'b0; e.pc_inc = 1'b0; end
      4'd7: if (!cf) begin e.ld[3] = 1'b0; e.pc_inc = 1'b0; end
      4'd9: begin e.pc_inc = 1'b0; e.halt = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  // Model: compare on the falling edge, then predict what the next rising edge does.
  initial begin
    exp_t       sched[$];
    exp_t       e;
    exp_t       idle;
    logic       m_known;
    logic       m_halt;
    logic       m_cflag;
    logic [3:0] m_imm;
    logic       er;
    idle.ld = 4'hF; idle.sel = 2'd3; idle.pc_inc = 1'b0; idle.exec = 1'b0; idle.halt = 1'b0;
    m_known = 1'b0; m_halt = 1'b0; m_cflag = 1'b0; m_imm = 4'd0;
    forever begin
      @(negedge clk);
      if (m_known) begin
        if (sched.size() > 0) begin
          e  = sched[0];
          er = 1'b0;
        end else begin
          e  = idle;
          er = n_reset & ~m_halt;
        end
        check("m_ld", 32'(ld), 32'(e.ld));
        check("m_sel", 32'(sel), 32'(e.sel));
        check("m_pc_inc", 32'(pc_inc), 32'(e.pc_inc));
        check("m_imm", 32'(imm), 32'(m_imm));
        check("m_halted", 32'(halted), 32'(m_halt && sched.size() == 0));
        check("m_ready", 32'(instr_ready), 32'(er));
      end
      if (!n_reset) begin
        m_known = 1'b1;
        sched.delete();
        m_halt  = 1'b0;
        m_cflag = 1'b0;
        m_imm   = 4'd0;
      end else if (m_known) begin
        if (sched.size() > 0) begin
          e = sched.pop_front();
          if (e.exec) m_cflag = c_in;
          if (e.halt) m_halt = 1'b1;
        end else if (!m_halt && instr_valid) begin
          sched.push_back(decode(instr, m_cflag));
          m_imm = instr[3:0];
          if (instr[8:5] == 4'd8) begin
            for (int k = 0; k < int'(instr[3:0]); k++) sched.push_back(idle);
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] op;
    logic [4:0] lo;
    n_reset = 1'b0; instr_valid = 1'b0; instr = '0; c_in = 1'b0;
    repeat (3) tick();
    n_reset = 1'b1;
    #1;
    check("rst_ld", 32'(ld), 32'h0F);
    check("rst_sel", 32'(sel), 32'h3);
    check("rst_imm", 32'(imm), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_ready", 32'(instr_ready), 32'h1);

    // ADD B,5
    instr = 9'b0000_1_0101; instr_valid = 1'b1;
    tick(); instr_valid = 1'b0; #1;
    check("add_ld", 32'(ld), 32'hD);
    check("add_sel", 32'(sel), 32'h1);
    check("add_imm", 32'(imm), 32'h5);
    check("add_pc_inc", 32'(pc_inc), 32'h1);
    check("add_ready", 32'(instr_ready), 32'h0);
    tick();
    check("add_back_ready", 32'(instr_ready), 32'h1);
    check("add_back_ld", 32'(ld), 32'hF);

    // carry set -> JNC not taken
    instr = 9'b0000_0_0001; instr_valid = 1'b1;
    tick(); instr_valid = 1'b0; c_in = 1'b1;
    tick(); c_in = 1'b0;
    instr = 9'b0111_0_1001; instr_valid = 1'b1;
    tick(); instr_valid = 1'b0; #1;
    check("jnc_c1_ld", 32'(ld), 32'hF);
    check("jnc_c1_pc_inc", 32'(pc_inc), 32'h1);
    tick();

    // carry clear -> JNC taken
    instr = 9'b0000_0_0001; instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    tick();
    instr = 9'b0111_0_1001; instr_valid = 1'b1;
    tick(); instr_valid = 1'b0; #1;
    check("jnc_c0_ld", 32'(ld), 32'h7);
    check("jnc_c0_sel", 32'(sel), 32'h3);
    check("jnc_c0_imm", 32'(imm), 32'h9);
    check("jnc_c0_pc_inc", 32'(pc_inc), 32'h0);
    tick();

    // WAIT 3: EXEC plus three wait cycles with ready low
    instr = 9'b1000_0_0011; instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("wait3_ready", 32'(instr_ready), 32'h0);
      check("wait3_ld", 32'(ld), 32'hF);
      tick();
    end
    check("wait3_done_ready", 32'(instr_ready), 32'h1);

    // WAIT 0 returns right after EXEC
    instr = 9'b1000_0_0000; instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    check("wait0_exec_ready", 32'(instr_ready), 32'h0);
    tick();
    check("wait0_done_ready", 32'(instr_ready), 32'h1);

    // HALT with a continuing valid stream
    instr = 9'b1001_0_0000; instr_valid = 1'b1;
    tick();
    check("halt_exec_pc_inc", 32'(pc_inc), 32'h0);
    instr = 9'b0110_0_0011;
    tick();
    for (int i = 0; i < 20; i++) begin
      check("halt_halted", 32'(halted), 32'h1);
      check("halt_ready", 32'(instr_ready), 32'h0);
      tick();
    end
    instr_valid = 1'b0; n_reset = 1'b0;
    tick(); n_reset = 1'b1; #1;
    check("halt_exit_halted", 32'(halted), 32'h0);
    check("halt_exit_ready", 32'(instr_ready), 32'h1);

    // reset in the second cycle of WAIT 7 clears the carry too
    instr = 9'b1000_0_0111; instr_valid = 1'b1;
    tick(); instr_valid = 1'b0; c_in = 1'b1;
    tick(); c_in = 1'b0;
    tick(); n_reset = 1'b0;
    tick(); n_reset = 1'b1; #1;
    check("wrst_ready", 32'(instr_ready), 32'h1);
    instr = 9'b0111_0_1001; instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    check("wrst_jnc_ld", 32'(ld), 32'h7);
    tick();

    // MOV A,B
    instr = 9'b0010_0_0001; instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    check("movr_ld", 32'(ld), 32'hE);
    check("movr_sel", 32'(sel), 32'h1);
    tick();

    // idle stream
    for (int i = 0; i < 10; i++) begin
      check("idle_ld", 32'(ld), 32'hF);
      check("idle_pc_inc", 32'(pc_inc), 32'h0);
      tick();
    end

    // randomized traffic, checked by the model only
    for (int c = 0; c < 2000; c++) begin
      n_reset     = ($urandom_range(0, 39) != 0);
      instr_valid = 1'($urandom_range(0, 1));
      op          = 4'($urandom_range(0, 15));
      if (op == 4'd9 && $urandom_range(0, 3) != 0) op = 4'd10;
      lo          = 5'($urandom);
      instr       = {op, lo};
      c_in        = 1'($urandom_range(0, 1));
      tick();
    end
    instr_valid = 1'b0;
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
